// File: rtl/out_bus_sequencer.sv
// out_bus_sequencer: queued address/data bus sequencer (setup, strobe, wait for ready).
// Optional macro BUS_TIMEOUT_EN aborts an access after TIMEOUT_CYC cycles without Mem_Ready.
module out_bus_sequencer #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [DATA_W-1:0]          Rx,
    input  logic [DATA_W-1:0]          Ry,
    input  logic [DATA_W-1:0]          NUM,
    input  logic [1:0]                 Sel_Op_OutBus,
    input  logic                       Op_Valid,
    output logic                       Op_Ready,
    input  logic                       Mem_Ready,
    input  logic [DATA_W-1:0]          i_DataIn_Bus,
    output logic [DATA_W-1:0]          o_DataOut_Bus,
    output logic [ADDR_W-1:0]          o_Addres_Data_Bus,
    output logic                       RW,
    output logic                       o_Bus_Strobe,
    output logic [DATA_W-1:0]          o_Read_Data,
    output logic                       o_Read_Valid,
    output logic [$clog2(DEPTH+1)-1:0] o_Queue_Count,
    output logic                       o_Bus_Busy,
    output logic                       o_Bus_Err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_q_rd   [DEPTH];
    logic [DATA_W-1:0] r_q_data [DEPTH];
    logic [ADDR_W-1:0] r_q_addr [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_is_rd;
    logic [DATA_W-1:0] r_data_out;
    logic [ADDR_W-1:0] r_addr_out;
    logic [DATA_W-1:0] r_read_data;
    logic              r_read_valid;

    logic              w_push;
    logic              w_pop;
    logic              w_done;
    logic              w_abort;
    logic              w_in_rd;
    logic [DATA_W-1:0] w_in_data;
    logic [DATA_W-1:0] w_in_addr_src;
    logic [ADDR_W-1:0] w_in_addr;

    assign Op_Ready  = (r_count < CNT_W'(DEPTH));
    assign w_push    = Op_Valid && Op_Ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign w_done    = (r_state == S_ACCESS) && Mem_Ready;
    assign w_in_addr = ADDR_W'(w_in_addr_src);

    // Decode the selected operation into direction, data and address source
    always_comb begin
        w_in_rd       = 1'b0;
        w_in_data     = Rx;
        w_in_addr_src = Ry;
        unique case (Sel_Op_OutBus)
            2'b00: w_in_rd = 1'b1;
            2'b01: w_in_data = Rx;
            2'b10: w_in_data = NUM;
            2'b11: w_in_addr_src = NUM;
        endcase
    end

    // Queue storage; flushing only needs the pointers, so no reset here
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_q_rd[r_wr_ptr]   <= w_in_rd;
            r_q_data[r_wr_ptr] <= w_in_data;
            r_q_addr[r_wr_ptr] <= w_in_addr;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Bus cycle state register
    always_ff @(posedge Clk) begin
        if (Rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Bus cycle sequencing: setup, strobe, wait for ready (or abort)
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_pop) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_done || w_abort) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Load the head entry onto the bus; reads leave the data bus untouched
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_is_rd    <= 1'b0;
            r_addr_out <= '0;
            r_data_out <= '0;
        end else if (w_pop) begin
            r_is_rd    <= r_q_rd[r_rd_ptr];
            r_addr_out <= r_q_addr[r_rd_ptr];
            if (!r_q_rd[r_rd_ptr]) r_data_out <= r_q_data[r_rd_ptr];
        end
    end

    // Capture read data on completion and pulse valid for one cycle
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_read_valid <= 1'b0;
            r_read_data  <= '0;
        end else begin
            r_read_valid <= w_done && r_is_rd;
            if (w_done && r_is_rd) r_read_data <= i_DataIn_Bus;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    // A ready in the last allowed cycle still completes normally
    assign w_abort = (r_state == S_ACCESS) && !Mem_Ready
                     && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Count access cycles spent waiting for ready
    always_ff @(posedge Clk) begin
        if (Rst)                      r_to_cnt <= '0;
        else if (r_state != S_ACCESS) r_to_cnt <= '0;
        else if (!Mem_Ready)          r_to_cnt <= r_to_cnt + TO_W'(1);
    end

    // One-cycle error pulse after an aborted access
    always_ff @(posedge Clk) begin
        if (Rst) r_err <= 1'b0;
        else     r_err <= w_abort;
    end

    assign o_Bus_Err = r_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign w_abort          = 1'b0;
    assign o_Bus_Err        = 1'b0;
`endif

    assign o_DataOut_Bus     = r_data_out;
    assign o_Addres_Data_Bus = r_addr_out;
    assign RW                = (r_state == S_IDLE) || r_is_rd;
    assign o_Bus_Strobe      = (r_state == S_ACCESS);
    assign o_Bus_Busy        = (r_state != S_IDLE);
    assign o_Read_Data       = r_read_data;
    assign o_Read_Valid      = r_read_valid;
    assign o_Queue_Count     = r_count;

endmodule
